// File: rtl/hold_window_ctrl_if.sv
// rtl/hold_window_ctrl_if.sv - control, config and pass-through signals of the hold window scheduler
interface hold_window_ctrl_if #(
  parameter int CTR_W  = 11,
  parameter int DATA_W = 1,
  parameter int CNT_W  = 8
);
  logic              start;
  logic              abort;
  logic [CTR_W-1:0]  cfg_offset;
  logic [CTR_W-1:0]  cfg_len;
  logic [CTR_W-1:0]  cfg_period;
  logic [CNT_W-1:0]  cfg_count;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              hold;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  win_idx;
  logic [CTR_W-1:0]  cyc_ctr;
  logic              mismatch;
  logic              err_sticky;

  modport master (
    output start, abort, cfg_offset, cfg_len, cfg_period, cfg_count, din,
    input  dout, hold, busy, done, win_idx, cyc_ctr, mismatch, err_sticky
  );

  modport slave (
    input  start, abort, cfg_offset, cfg_len, cfg_period, cfg_count, din,
    output dout, hold, busy, done, win_idx, cyc_ctr, mismatch, err_sticky
  );
endinterface

// File: rtl/hold_window_ctrl.sv
// rtl/hold_window_ctrl.sv - hold window scheduler with owned pass-through register stage
module hold_window_ctrl #(
  parameter int CTR_W  = 11,
  parameter int DATA_W = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  hold_window_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OFFSET,
    S_HOLD,
    S_GAP,
    S_DONE
  } state_t;

  state_t            state;
  state_t            nxt;
  logic [CTR_W-1:0]  seg_left;
  logic [CTR_W-1:0]  seg_nxt;
  logic [CTR_W-1:0]  lat_len;
  logic [CTR_W-1:0]  lat_per;
  logic [CNT_W-1:0]  lat_cnt;
  logic [CTR_W-1:0]  src_len;
  logic [CTR_W-1:0]  len_eff;
  logic [CNT_W-1:0]  win_nxt;
  logic              win_inc;
  logic              accept;
  logic              busy_now;

  logic [DATA_W-1:0] dout_r;
  logic              hold_r;
  logic              busy_r;
  logic              done_r;
  logic [CNT_W-1:0]  win_r;
  logic [CTR_W-1:0]  cyc_r;
  logic              mis_r;
  logic              err_r;

  assign accept   = (state == S_IDLE) && bus.start && !bus.abort;
  assign busy_now = (state == S_OFFSET) || (state == S_HOLD) || (state == S_GAP);
  // Config is live on the inputs only at acceptance; afterwards the latched copy rules.
  assign src_len  = (state == S_IDLE) ? bus.cfg_len : lat_len;
  // A zero-length window still occupies one step so win_idx and period spacing advance.
  assign len_eff  = (src_len == '0) ? CTR_W'(1) : src_len;
  assign win_nxt  = win_r + CNT_W'(1);

  always_comb begin
    nxt     = state;
    seg_nxt = seg_left;
    win_inc = 1'b0;
    if (bus.abort && state != S_IDLE) begin
      nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (bus.cfg_count == '0) begin
              nxt = S_DONE;
            end else if (bus.cfg_offset != '0) begin
              nxt     = S_OFFSET;
              seg_nxt = bus.cfg_offset - CTR_W'(1);
            end else begin
              nxt     = S_HOLD;
              seg_nxt = len_eff - CTR_W'(1);
            end
          end
        end
        S_OFFSET, S_GAP: begin
          if (seg_left == '0) begin
            nxt     = S_HOLD;
            seg_nxt = len_eff - CTR_W'(1);
          end else begin
            seg_nxt = seg_left - CTR_W'(1);
          end
        end
        S_HOLD: begin
          if (seg_left == '0) begin
            win_inc = 1'b1;
            if (win_nxt == lat_cnt) begin
              nxt = S_DONE;
            end else if (lat_per > len_eff) begin
              nxt     = S_GAP;
              seg_nxt = lat_per - len_eff - CTR_W'(1);
            end else begin
              nxt     = S_HOLD;
              seg_nxt = len_eff - CTR_W'(1);
            end
          end else begin
            seg_nxt = seg_left - CTR_W'(1);
          end
        end
        S_DONE:  nxt = S_IDLE;
        default: nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      seg_left <= '0;
      lat_len  <= '0;
      lat_per  <= '0;
      lat_cnt  <= '0;
      dout_r   <= '0;
      hold_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      win_r    <= '0;
      cyc_r    <= '0;
      mis_r    <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state    <= nxt;
      seg_left <= seg_nxt;
      if (accept) begin
        lat_len <= bus.cfg_len;
        lat_per <= bus.cfg_period;
        lat_cnt <= bus.cfg_count;
        cyc_r   <= '0;
        win_r   <= '0;
      end else begin
        if (busy_now && !bus.abort) cyc_r <= cyc_r + CTR_W'(1);
        if (win_inc)                win_r <= win_nxt;
      end
      hold_r <= (nxt == S_HOLD) && (src_len != '0);
      busy_r <= (nxt == S_OFFSET) || (nxt == S_HOLD) || (nxt == S_GAP);
      done_r <= (nxt == S_DONE);
      // Pass-through stage freezes on the hold value visible before this edge.
      dout_r <= hold_r ? dout_r : bus.din;
      mis_r  <= (bus.din != dout_r);
      if (accept)               err_r <= 1'b0;
      else if (mis_r && !hold_r) err_r <= 1'b1;
    end
  end

  assign bus.dout       = dout_r;
  assign bus.hold       = hold_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.win_idx    = win_r;
  assign bus.cyc_ctr    = cyc_r;
  assign bus.mismatch   = mis_r;
  assign bus.err_sticky = err_r;

endmodule
